exec_op_control: RTL and testbench
==================================

# exec_op_control

Next-generation EX-stage operation controller: decodes opcode/funct into ALU operation and shift-amount select, and also sequences the iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) through a small FSM. It stalls the pipeline while an operation is in flight and raises HI/LO write-enable on completion. It also steers MFHI/MFLO reads. Sits between the ID/EX register and the ALU / mul-div datapath, beside the hazard unit.

## Interface
- NB_FCODE, 6, funct field width
- NB_OPCODE, 6, opcode field width
- NB_ALU_OP, 4, ALU operation code width
- MD_CYCLES, 32, busy cycles of the iterative mul/div unit; legal range 1..255
- NB_CNT, 8, cycle counter width; must satisfy 2^NB_CNT > MD_CYCLES
- i_clk  in  1  clock; all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  EX holds a valid instruction
- i_flush  in  1  squash the EX instruction; aborts any mul/div in flight
- i_funct_code  in  NB_FCODE  funct field
- i_instruction_opcode  in  NB_OPCODE  opcode field
- o_alu_operation  out  NB_ALU_OP  ALU op, combinational
- o_shamt_ctrl  out  1  1 selects shamt as ALU operand A, combinational
- o_hilo_sel  out  2  01 = MFHI, 10 = MFLO, 00 = ALU result, combinational
- o_md_start  out  1  one-cycle start pulse to mul/div unit, registered
- o_md_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; latched at accept
- o_stall  out  1  freeze IF/ID/EX
- o_hilo_we  out  1  one-cycle HI/LO write enable, registered
- o_busy  out  1  FSM not in IDLE

## Operation
- Decode is purely combinational; defaults o_alu_operation = 0, o_shamt_ctrl = 0, o_hilo_sel = 00.
- R-type funct map:
  - ADD/ADDU → `ADD; SUB/SUBU → `SUB.
  - AND/OR/XOR/NOR/SLT → same-named op.
  - SLL/SRL/SRA → same-named op with o_shamt_ctrl = 1.
  - MFHI (010000) → o_hilo_sel = 01; MFLO (010010) → o_hilo_sel = 10.
- I-type map: ADDI/LW/SW → `ADD; BEQ → `SUB; BNE → `BNE. Any other opcode → defaults.
- MD functs: 011000/011001/011010/011011 map to o_md_op 00/01/10/11.
- FSM states:
  - IDLE: on i_valid & MD funct & !i_flush, latch o_md_op, load counter = MD_CYCLES, go to RUN.
  - RUN: decrement counter each cycle; at counter == 1 go to DONE; on i_flush go to IDLE with no write.
  - DONE: go to IDLE unconditionally.
- o_md_start = 1 only in the first RUN cycle.
- o_stall = (IDLE & accept condition) | RUN. The accept-cycle term is combinational.
- o_hilo_we = 1 only in DONE; o_stall = 0 in DONE.
- Inputs are ignored outside IDLE; the stalled MD instruction stays at the inputs during RUN/DONE and is not re-accepted.
- MFHI/MFLO decoded in IDLE while no operation is pending read the committed HI/LO. Any MFHI/MFLO issued after an MD is held by the stall until DONE.

## Timing
- Reset (async): state IDLE, counter 0, o_md_op 00, o_md_start 0, o_hilo_we 0, o_busy 0, o_stall 0.
- Accept at cycle T:
  - o_stall high from T through T+MD_CYCLES.
  - o_md_start high at T+1.
  - o_hilo_we high at T+MD_CYCLES+1.
  - o_busy high T+1 .. T+MD_CYCLES+1.
- Total pipeline freeze per mul/div = MD_CYCLES+1 cycles.
- MD_CYCLES = 1: RUN lasts one cycle, with start and last-count coinciding.
- i_flush in the accept cycle: no accept. i_flush in RUN: next cycle IDLE, o_stall 0, no o_hilo_we. i_flush in DONE: ignored; the write still occurs.
- Reset mid-RUN: immediate IDLE, no o_hilo_we.
- Back-to-back MD instructions: the second is accepted no earlier than the cycle after DONE.

## Configuration
- EXEC_MULDIV_EN defined: FSM, counter and mul/div outputs present as above.
- EXEC_MULDIV_EN undefined:
  - FSM and counter are removed.
  - o_md_start, o_md_op, o_stall, o_hilo_we, o_busy are tied 0.
  - MD and MFHI/MFLO functs decode to defaults.
  - The remaining decode is unchanged.

## Test plan
- Reset asserted mid-RUN with MD_CYCLES = 4 → all registered outputs 0 immediately; o_busy 0; no o_hilo_we after release.
- Opcode 000000 with funct 100000, 000000, 101010, and opcode 000101 → `ADD/0, `SLL/1, `SLT/0, `BNE; o_stall stays 0.
- MD_CYCLES = 4, DIV (funct 011010) accepted at T:
  - o_md_op = 10.
  - o_stall high T..T+4.
  - o_md_start at T+1.
  - o_hilo_we at T+5 only.
- MULT, then MFLO issued directly after:
  - MFLO is held (o_stall 1) until DONE.
  - Afterwards o_hilo_sel = 10 in IDLE with o_stall 0.
- i_flush in the second RUN cycle → IDLE the next cycle; o_hilo_we never asserts; next MULTU is accepted normally with o_md_op = 01.
- MD_CYCLES = 1 with back-to-back MULT,MULT → o_md_start at T+1 and T+4; o_hilo_we at T+2 and T+5.

Source files
------------

// File: rtl/exec_op_control.sv
// exec_op_control
//   EX-stage operation controller. Decodes opcode/funct into an ALU operation
//   and shift-amount select, steers MFHI/MFLO reads, and sequences the
//   iterative mul/div unit (MULT, MULTU, DIV, DIVU) through a small FSM that
//   freezes the pipeline while an operation is in flight.
//
//   Optional feature macro: EXEC_MULDIV_EN
//     defined   : mul/div FSM, cycle counter and mul/div outputs present.
//     undefined : FSM removed; o_md_start, o_md_op, o_stall, o_hilo_we and
//                 o_busy tied 0; MD and MFHI/MFLO functs decode to defaults.
//
// Ports
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_valid, i_flush       EX holds a valid instruction / squash it
//   i_funct_code           funct field
//   i_instruction_opcode   opcode field
//   o_alu_operation        ALU operation (combinational)
//   o_shamt_ctrl           1 selects shamt as ALU operand A (combinational)
//   o_hilo_sel             01 MFHI, 10 MFLO, 00 ALU result (combinational)
//   o_md_start             one-cycle start pulse to mul/div unit (registered)
//   o_md_op                00 MULT, 01 MULTU, 10 DIV, 11 DIVU (latched)
//   o_stall                freeze IF/ID/EX
//   o_hilo_we              one-cycle HI/LO write enable (registered)
//   o_busy                 FSM not in IDLE
module exec_op_control #(
  parameter int NB_FCODE  = 6,
  parameter int NB_OPCODE = 6,
  parameter int NB_ALU_OP = 4,
  parameter int MD_CYCLES = 32,
  parameter int NB_CNT    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [NB_FCODE-1:0]  i_funct_code,
  input  logic [NB_OPCODE-1:0] i_instruction_opcode,
  output logic [NB_ALU_OP-1:0] o_alu_operation,
  output logic                 o_shamt_ctrl,
  output logic [1:0]           o_hilo_sel,
  output logic                 o_md_start,
  output logic [1:0]           o_md_op,
  output logic                 o_stall,
  output logic                 o_hilo_we,
  output logic                 o_busy
);

  // ALU operation encoding; 0 is reserved for "no operation / default".
  localparam logic [NB_ALU_OP-1:0] ALU_ADD = NB_ALU_OP'(1);
  localparam logic [NB_ALU_OP-1:0] ALU_SUB = NB_ALU_OP'(2);
  localparam logic [NB_ALU_OP-1:0] ALU_AND = NB_ALU_OP'(3);
  localparam logic [NB_ALU_OP-1:0] ALU_OR  = NB_ALU_OP'(4);
  localparam logic [NB_ALU_OP-1:0] ALU_XOR = NB_ALU_OP'(5);
  localparam logic [NB_ALU_OP-1:0] ALU_NOR = NB_ALU_OP'(6);
  localparam logic [NB_ALU_OP-1:0] ALU_SLT = NB_ALU_OP'(7);
  localparam logic [NB_ALU_OP-1:0] ALU_SLL = NB_ALU_OP'(8);
  localparam logic [NB_ALU_OP-1:0] ALU_SRL = NB_ALU_OP'(9);
  localparam logic [NB_ALU_OP-1:0] ALU_SRA = NB_ALU_OP'(10);
  localparam logic [NB_ALU_OP-1:0] ALU_BNE = NB_ALU_OP'(11);

  localparam logic [NB_OPCODE-1:0] OP_RTYPE = NB_OPCODE'(6'b000000);
  localparam logic [NB_OPCODE-1:0] OP_ADDI  = NB_OPCODE'(6'b001000);
  localparam logic [NB_OPCODE-1:0] OP_LW    = NB_OPCODE'(6'b100011);
  localparam logic [NB_OPCODE-1:0] OP_SW    = NB_OPCODE'(6'b101011);
  localparam logic [NB_OPCODE-1:0] OP_BEQ   = NB_OPCODE'(6'b000100);
  localparam logic [NB_OPCODE-1:0] OP_BNE   = NB_OPCODE'(6'b000101);

  localparam logic [NB_FCODE-1:0] F_SLL   = NB_FCODE'(6'b000000);
  localparam logic [NB_FCODE-1:0] F_SRL   = NB_FCODE'(6'b000010);
  localparam logic [NB_FCODE-1:0] F_SRA   = NB_FCODE'(6'b000011);
  localparam logic [NB_FCODE-1:0] F_ADD   = NB_FCODE'(6'b100000);
  localparam logic [NB_FCODE-1:0] F_ADDU  = NB_FCODE'(6'b100001);
  localparam logic [NB_FCODE-1:0] F_SUB   = NB_FCODE'(6'b100010);
  localparam logic [NB_FCODE-1:0] F_SUBU  = NB_FCODE'(6'b100011);
  localparam logic [NB_FCODE-1:0] F_AND   = NB_FCODE'(6'b100100);
  localparam logic [NB_FCODE-1:0] F_OR    = NB_FCODE'(6'b100101);
  localparam logic [NB_FCODE-1:0] F_XOR   = NB_FCODE'(6'b100110);
  localparam logic [NB_FCODE-1:0] F_NOR   = NB_FCODE'(6'b100111);
  localparam logic [NB_FCODE-1:0] F_SLT   = NB_FCODE'(6'b101010);
`ifdef EXEC_MULDIV_EN
  localparam logic [NB_FCODE-1:0] F_MFHI  = NB_FCODE'(6'b010000);
  localparam logic [NB_FCODE-1:0] F_MFLO  = NB_FCODE'(6'b010010);
  localparam logic [NB_FCODE-1:0] F_MULT  = NB_FCODE'(6'b011000);
  localparam logic [NB_FCODE-1:0] F_MULTU = NB_FCODE'(6'b011001);
  localparam logic [NB_FCODE-1:0] F_DIV   = NB_FCODE'(6'b011010);
  localparam logic [NB_FCODE-1:0] F_DIVU  = NB_FCODE'(6'b011011);
`endif

  // Combinational ALU / operand / HI-LO read decode
  always_comb begin
    o_alu_operation = '0;
    o_shamt_ctrl    = 1'b0;
    o_hilo_sel      = 2'b00;
    if (i_instruction_opcode == OP_RTYPE) begin
      case (i_funct_code)
        F_ADD, F_ADDU: o_alu_operation = ALU_ADD;
        F_SUB, F_SUBU: o_alu_operation = ALU_SUB;
        F_AND:         o_alu_operation = ALU_AND;
        F_OR:          o_alu_operation = ALU_OR;
        F_XOR:         o_alu_operation = ALU_XOR;
        F_NOR:         o_alu_operation = ALU_NOR;
        F_SLT:         o_alu_operation = ALU_SLT;
        F_SLL: begin o_alu_operation = ALU_SLL; o_shamt_ctrl = 1'b1; end
        F_SRL: begin o_alu_operation = ALU_SRL; o_shamt_ctrl = 1'b1; end
        F_SRA: begin o_alu_operation = ALU_SRA; o_shamt_ctrl = 1'b1; end
`ifdef EXEC_MULDIV_EN
        F_MFHI:        o_hilo_sel = 2'b01;
        F_MFLO:        o_hilo_sel = 2'b10;
`endif
        default: ;
      endcase
    end else begin
      case (i_instruction_opcode)
        OP_ADDI, OP_LW, OP_SW: o_alu_operation = ALU_ADD;
        OP_BEQ:                o_alu_operation = ALU_SUB;
        OP_BNE:                o_alu_operation = ALU_BNE;
        default: ;
      endcase
    end
  end

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic [1:0]        md_op_q, md_op_d;
  logic              md_start_q, md_start_d;
  logic              hilo_we_q, hilo_we_d;
  logic              md_funct;
  logic [1:0]        md_op_dec;
  logic              accept;

  always_comb begin
    md_funct  = 1'b0;
    md_op_dec = 2'b00;
    if (i_instruction_opcode == OP_RTYPE) begin
      case (i_funct_code)
        F_MULT:  begin md_funct = 1'b1; md_op_dec = 2'b00; end
        F_MULTU: begin md_funct = 1'b1; md_op_dec = 2'b01; end
        F_DIV:   begin md_funct = 1'b1; md_op_dec = 2'b10; end
        F_DIVU:  begin md_funct = 1'b1; md_op_dec = 2'b11; end
        default: ;
      endcase
    end
  end

  // Only IDLE looks at the inputs: the stalled MD instruction sitting at the
  // inputs during RUN/DONE must not be taken a second time.
  assign accept = (state_q == S_IDLE) && i_valid && md_funct && !i_flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_op_d    = md_op_q;
    md_start_d = 1'b0;
    hilo_we_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_RUN;
          cnt_d      = NB_CNT'(MD_CYCLES);
          md_op_d    = md_op_dec;
          md_start_d = 1'b1;
        end
      end
      S_RUN: begin
        if (i_flush) begin
          // Abort: no HI/LO write for a squashed operation.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - NB_CNT'(1);
          if (cnt_q == NB_CNT'(1)) begin
            state_d   = S_DONE;
            hilo_we_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      md_op_q    <= 2'b00;
      md_start_q <= 1'b0;
      hilo_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_op_q    <= md_op_d;
      md_start_q <= md_start_d;
      hilo_we_q  <= hilo_we_d;
    end
  end

  assign o_md_start = md_start_q;
  assign o_md_op    = md_op_q;
  assign o_hilo_we  = hilo_we_q;
  assign o_busy     = (state_q != S_IDLE);
  // The accept-cycle term is combinational so the MD instruction freezes in
  // EX in the same cycle it is seen; reset masks it so stall reads 0.
  assign o_stall    = !i_reset && (accept || (state_q == S_RUN));
`else
  logic unused_inputs;
  assign unused_inputs = ^{i_clk, i_reset, i_valid, i_flush};

  assign o_md_start = 1'b0;
  assign o_md_op    = 2'b00;
  assign o_hilo_we  = 1'b0;
  assign o_busy     = 1'b0;
  assign o_stall    = 1'b0;
`endif

endmodule

// File: tb/tb_exec_op_control.sv
// Directed testbench for exec_op_control. Two instances share the stimulus:
// u_dut4 (MD_CYCLES = 4) and u_dut1 (MD_CYCLES = 1); each scenario checks
// the instance it targets and resets both beforehand.
module tb_exec_op_control;

  localparam logic [3:0] A_NONE = 4'd0;
  localparam logic [3:0] A_ADD  = 4'd1;
  localparam logic [3:0] A_SUB  = 4'd2;
  localparam logic [3:0] A_NOR  = 4'd6;
  localparam logic [3:0] A_SLT  = 4'd7;
  localparam logic [3:0] A_SLL  = 4'd8;
  localparam logic [3:0] A_SRL  = 4'd9;
  localparam logic [3:0] A_SRA  = 4'd10;
  localparam logic [3:0] A_BNE  = 4'd11;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       flush;
  logic [5:0] funct;
  logic [5:0] opc;

  logic [3:0] a_alu;  logic a_sh;  logic [1:0] a_sel;
  logic       a_start; logic [1:0] a_mdop; logic a_stall; logic a_we; logic a_busy;
  logic [3:0] b_alu;  logic b_sh;  logic [1:0] b_sel;
  logic       b_start; logic [1:0] b_mdop; logic b_stall; logic b_we; logic b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exec_op_control #(.MD_CYCLES(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_flush(flush),
    .i_funct_code(funct), .i_instruction_opcode(opc),
    .o_alu_operation(a_alu), .o_shamt_ctrl(a_sh), .o_hilo_sel(a_sel),
    .o_md_start(a_start), .o_md_op(a_mdop), .o_stall(a_stall),
    .o_hilo_we(a_we), .o_busy(a_busy)
  );

  exec_op_control #(.MD_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_flush(flush),
    .i_funct_code(funct), .i_instruction_opcode(opc),
    .o_alu_operation(b_alu), .o_shamt_ctrl(b_sh), .o_hilo_sel(b_sel),
    .o_md_start(b_start), .o_md_op(b_mdop), .o_stall(b_stall),
    .o_hilo_we(b_we), .o_busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic fl, input logic [5:0] op, input logic [5:0] fn);
    valid = v;
    flush = fl;
    opc   = op;
    funct = fn;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 6'b0, 6'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic dec_vec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [3:0] alu, input logic sh, input logic [1:0] sel);
    set_in(1'b1, 1'b0, op, fn);
    #1;
    check_eq({tag, "_alu"},   32'(a_alu),   32'(alu));
    check_eq({tag, "_shamt"}, 32'(a_sh),    32'(sh));
    check_eq({tag, "_sel"},   32'(a_sel),   32'(sel));
    check_eq({tag, "_stall"}, 32'(a_stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 6'b0, 6'b0);
    #2;
    check_eq("rst_busy",  32'(a_busy),  32'd0);
    check_eq("rst_start", 32'(a_start), 32'd0);
    check_eq("rst_we",    32'(a_we),    32'd0);
    check_eq("rst_mdop",  32'(a_mdop),  32'd0);
    check_eq("rst_stall", 32'(a_stall), 32'd0);
    step();
    rst = 1'b0;

    // Combinational decode table
    dec_vec("add",  6'b000000, 6'b100000, A_ADD,  1'b0, 2'b00);
    dec_vec("addu", 6'b000000, 6'b100001, A_ADD,  1'b0, 2'b00);
    dec_vec("subu", 6'b000000, 6'b100011, A_SUB,  1'b0, 2'b00);
    dec_vec("nor",  6'b000000, 6'b100111, A_NOR,  1'b0, 2'b00);
    dec_vec("slt",  6'b000000, 6'b101010, A_SLT,  1'b0, 2'b00);
    dec_vec("sll",  6'b000000, 6'b000000, A_SLL,  1'b1, 2'b00);
    dec_vec("srl",  6'b000000, 6'b000010, A_SRL,  1'b1, 2'b00);
    dec_vec("sra",  6'b000000, 6'b000011, A_SRA,  1'b1, 2'b00);
    dec_vec("bne",  6'b000101, 6'b100000, A_BNE,  1'b0, 2'b00);
    dec_vec("beq",  6'b000100, 6'b000000, A_SUB,  1'b0, 2'b00);
    dec_vec("lw",   6'b100011, 6'b000000, A_ADD,  1'b0, 2'b00);
    dec_vec("lui",  6'b001111, 6'b100000, A_NONE, 1'b0, 2'b00);
    dec_vec("jr",   6'b000000, 6'b001000, A_NONE, 1'b0, 2'b00);
`ifdef EXEC_MULDIV_EN
    dec_vec("mfhi", 6'b000000, F_MFHI, A_NONE, 1'b0, 2'b01);
    dec_vec("mflo", 6'b000000, F_MFLO, A_NONE, 1'b0, 2'b10);

    // DIV on MD_CYCLES = 4, accepted at T
    do_reset();
    set_in(1'b1, 1'b0, 6'b0, F_DIV);
    #1;
    check_eq("div_T_stall", 32'(a_stall), 32'd1);
    check_eq("div_T_start", 32'(a_start), 32'd0);
    check_eq("div_T_busy",  32'(a_busy),  32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 5) set_in(1'b0, 1'b0, 6'b0, 6'b0);
      #1;
      check_eq($sformatf("div_T%0d_stall", k), 32'(a_stall), 32'(k <= 4));
      check_eq($sformatf("div_T%0d_start", k), 32'(a_start), 32'(k == 1));
      check_eq($sformatf("div_T%0d_we", k),    32'(a_we),    32'(k == 5));
      check_eq($sformatf("div_T%0d_busy", k),  32'(a_busy),  32'd1);
      check_eq($sformatf("div_T%0d_mdop", k),  32'(a_mdop),  32'd2);
    end
    step();
    check_eq("div_T6_busy", 32'(a_busy), 32'd0);
    check_eq("div_T6_we",   32'(a_we),   32'd0);

    // MULT followed by MFLO held behind it
    do_reset();
    set_in(1'b1, 1'b0, 6'b0, F_MULT);
    #1;
    check_eq("mult_T_stall", 32'(a_stall), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("mult_T%0d_stall", k), 32'(a_stall), 32'd1);
    end
    check_eq("mult_mdop", 32'(a_mdop), 32'd0);
    step();
    check_eq("mult_done_stall", 32'(a_stall), 32'd0);
    check_eq("mult_done_we",    32'(a_we),    32'd1);
    step();
    set_in(1'b1, 1'b0, 6'b0, F_MFLO);
    #1;
    check_eq("mflo_sel",   32'(a_sel),   32'd2);
    check_eq("mflo_stall", 32'(a_stall), 32'd0);
    check_eq("mflo_busy",  32'(a_busy),  32'd0);
    step();
    check_eq("mflo_no_accept", 32'(a_busy), 32'd0);

    // Flush in the accept cycle: nothing accepted
    do_reset();
    set_in(1'b1, 1'b1, 6'b0, F_MULT);
    #1;
    check_eq("flacc_stall", 32'(a_stall), 32'd0);
    step();
    check_eq("flacc_busy",  32'(a_busy),  32'd0);
    check_eq("flacc_start", 32'(a_start), 32'd0);

    // Flush in the second RUN cycle, then MULTU
    do_reset();
    set_in(1'b1, 1'b0, 6'b0, F_MULT);
    step();
    check_eq("flrun_start", 32'(a_start), 32'd1);
    step();
    flush = 1'b1;
    #1;
    check_eq("flrun_busy", 32'(a_busy), 32'd1);
    step();
    set_in(1'b0, 1'b0, 6'b0, 6'b0);
    #1;
    check_eq("flrun_idle_busy",  32'(a_busy),  32'd0);
    check_eq("flrun_idle_stall", 32'(a_stall), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("flrun_we_%0d", k), 32'(a_we), 32'd0);
      step();
    end
    set_in(1'b1, 1'b0, 6'b0, F_MULTU);
    #1;
    check_eq("multu_T_stall", 32'(a_stall), 32'd1);
    step();
    check_eq("multu_mdop",  32'(a_mdop),  32'd1);
    check_eq("multu_start", 32'(a_start), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      step();
      if (k == 5) set_in(1'b0, 1'b0, 6'b0, 6'b0);
      #1;
      check_eq($sformatf("multu_T%0d_we", k), 32'(a_we), 32'(k == 5));
    end

    // Back-to-back MULT on MD_CYCLES = 1
    do_reset();
    set_in(1'b1, 1'b0, 6'b0, F_MULT);
    for (int k = 0; k <= 5; k++) begin
      #1;
      check_eq($sformatf("b2b_T%0d_start", k), 32'(b_start), 32'(k == 1 || k == 4));
      check_eq($sformatf("b2b_T%0d_we", k),    32'(b_we),    32'(k == 2 || k == 5));
      check_eq($sformatf("b2b_T%0d_stall", k), 32'(b_stall), 32'(k == 0 || k == 1 || k == 3 || k == 4));
      step();
    end
    set_in(1'b0, 1'b0, 6'b0, 6'b0);

    // Reset asserted mid-RUN on MD_CYCLES = 4
    do_reset();
    set_in(1'b1, 1'b0, 6'b0, F_DIV);
    step();
    step();
    #1;
    check_eq("rrun_pre_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rrun_busy",  32'(a_busy),  32'd0);
    check_eq("rrun_mdop",  32'(a_mdop),  32'd0);
    check_eq("rrun_stall", 32'(a_stall), 32'd0);
    check_eq("rrun_we",    32'(a_we),    32'd0);
    check_eq("rrun_start", 32'(a_start), 32'd0);
    set_in(1'b0, 1'b0, 6'b0, 6'b0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq($sformatf("rrun_after_we_%0d", k), 32'(a_we), 32'd0);
      check_eq($sformatf("rrun_after_busy_%0d", k), 32'(a_busy), 32'd0);
    end
`else
    // Mul/div removed: MD and HI/LO functs decode to defaults, outputs tied 0
    dec_vec("mfhi_off", 6'b000000, F_MFHI, A_NONE, 1'b0, 2'b00);
    dec_vec("mflo_off", 6'b000000, F_MFLO, A_NONE, 1'b0, 2'b00);
    dec_vec("div_off",  6'b000000, F_DIV,  A_NONE, 1'b0, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq($sformatf("off_start_%0d", k), 32'(a_start), 32'd0);
      check_eq($sformatf("off_busy_%0d", k),  32'(a_busy),  32'd0);
      check_eq($sformatf("off_we_%0d", k),    32'(a_we),    32'd0);
      check_eq($sformatf("off_mdop_%0d", k),  32'(a_mdop),  32'd0);
      check_eq($sformatf("off_stall_%0d", k), 32'(b_stall), 32'd0);
    end
    set_in(1'b0, 1'b0, 6'b0, 6'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
